// File: rtl/trng_pkg.sv
// trng_pkg: default ring generator taps and a parameter-legality check.
package trng_pkg;
  localparam logic [15:0] TAPS16 = 16'h3400;
  localparam logic [31:0] TAPS32 = 32'h0410_8210;
  localparam logic [63:0] TAPS64 = 64'h5800_0000_0000_0000;
  function automatic logic params_ok(int width, int no_inj, int inj_base, int inj_stride,
                                     int decim, int out_w, int rct_limit);
    return width >= 8 && no_inj >= 1 && inj_base >= 0 && inj_stride >= 1 &&
           inj_base + (no_inj - 1) * inj_stride < width - 1 &&
           decim >= 1 && out_w >= 2 && rct_limit >= 2;
  endfunction
endpackage

// File: rtl/trng_ring_core.sv
// trng_ring_core: Galois ring generator state register with entropy injection.
module trng_ring_core #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = 32'h0410_8210,
  parameter int NO_INJ = 5,
  parameter int INJ_BASE = 2,
  parameter int INJ_STRIDE = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_load,
  input  logic [NO_INJ-1:0] i_w,
  input  logic [WIDTH-1:0]  i_seed,
  output logic [WIDTH-1:0]  o_state
);
  logic [WIDTH-1:0] state_q, state_d, inj;
  always_comb begin
    inj = '0;
    for (int j = 0; j < NO_INJ; j++) inj[INJ_BASE + j * INJ_STRIDE] = i_w[j];
    state_d = i_load ? i_seed :
              i_en   ? ({state_q[0], state_q[WIDTH-1:1]} ^
                        ({1'b0, TAPS[WIDTH-2:0]} & {WIDTH{state_q[0]}}) ^ inj) :
                       state_q;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state_q <= '0;
    else       state_q <= state_d;
  assign o_state = state_q;
endmodule

// File: rtl/trng_ring_collector.sv
// trng_ring_collector: ring generator with decimation, word packing, valid/ready
// delivery, overrun flag and repetition-count health alarm.
module trng_ring_collector
  import trng_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = TAPS32,
  parameter int NO_INJ = 5,
  parameter int INJ_BASE = 2,
  parameter int INJ_STRIDE = 3,
  parameter int DECIM = 4,
  parameter int OUT_W = 8,
  parameter int RCT_LIMIT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [NO_INJ-1:0] i_w,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_seed,
  input  logic              i_clr,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_word,
  output logic [WIDTH-1:0]  o_state,
  output logic              o_pulse,
  output logic              o_overrun,
  output logic              o_alarm
);
  localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int CW = $clog2(OUT_W);
  localparam int RW = $clog2(RCT_LIMIT + 1);
  if (!params_ok(WIDTH, NO_INJ, INJ_BASE, INJ_STRIDE, DECIM, OUT_W, RCT_LIMIT)) begin : g_bad
    $error("trng_ring_collector: illegal parameter set");
  end
  logic [WIDTH-1:0] state;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic [OUT_W-2:0] sh_q, sh_d;
  logic [OUT_W-1:0] word_q, word_d, new_word;
  logic last_q, last_d, valid_q, valid_d, ovr_q, ovr_d, alarm_q, alarm_d;
  logic samp, rise, done, ovf, deliver;
  trng_ring_core #(
    .WIDTH(WIDTH), .TAPS(TAPS), .NO_INJ(NO_INJ), .INJ_BASE(INJ_BASE), .INJ_STRIDE(INJ_STRIDE)
  ) u_core (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_load(i_load),
    .i_w(i_w), .i_seed(i_seed), .o_state(state)
  );
  always_comb begin
    samp = i_en & ~i_load & (dcnt_q == DW'(DECIM - 1));
    // run_q == 0 marks "no sample since load/reset", so the next sample starts a run of 1
    run_inc = (run_q != '0 && state[0] == last_q) ?
              (run_q == RW'(RCT_LIMIT) ? run_q : run_q + 1'b1) : RW'(1);
    rise = samp & (run_inc == RW'(RCT_LIMIT));
    done = samp & (bcnt_q == CW'(OUT_W - 1));
    new_word = {state[0], sh_q};
    ovf = done & ~(alarm_q | rise) & valid_q & ~i_ready;
    deliver = done & ~(alarm_q | rise) & ~ovf;
    dcnt_d = i_load ? '0 : i_en ? (samp ? '0 : dcnt_q + 1'b1) : dcnt_q;
    bcnt_d = i_load ? '0 : samp ? (done ? '0 : bcnt_q + 1'b1) : bcnt_q;
    run_d = i_load ? '0 : samp ? run_inc : run_q;
    last_d = samp ? state[0] : last_q;
    sh_d = samp ? new_word[OUT_W-1:1] : sh_q;
    word_d = deliver ? new_word : word_q;
    valid_d = deliver | (valid_q & ~i_ready);
    ovr_d = ovf | (ovr_q & ~i_clr);
    alarm_d = rise | (alarm_q & ~i_clr);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      dcnt_q <= '0;
      bcnt_q <= '0;
      run_q <= '0;
      last_q <= 1'b0;
      sh_q <= '0;
      word_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      bcnt_q <= bcnt_d;
      run_q <= run_d;
      last_q <= last_d;
      sh_q <= sh_d;
      word_q <= word_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
      alarm_q <= alarm_d;
    end
  assign o_valid = valid_q;
  assign o_word = word_q;
  assign o_state = state;
  assign o_pulse = state[0];
  assign o_overrun = ovr_q;
  assign o_alarm = alarm_q;
endmodule

// File: tb/tb_trng_ring_collector.sv
// tb_trng_ring_collector: directed single-step vectors plus hand-written
// packing, overrun, health and async-reset sequences on two configurations.
module tb_trng_ring_collector;
  logic clk = 1'b0, rst, en, load, clr, ready;
  logic [4:0] w;
  logic [31:0] seed;
  logic v0, p0, ov0, al0, v1, p1, ov1, al1;
  logic [7:0] wd0, wd1;
  logic [31:0] st0, st1;
  int checks = 0, failures = 0, vcnt;
  typedef struct {
    logic [31:0] seed;
    logic [4:0]  w;
    logic [31:0] st;
    logic        p;
  } vec_t;
  vec_t tv[7];
  always #5 clk = ~clk;
  trng_ring_collector u0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_w(w), .i_load(load), .i_seed(seed),
    .i_clr(clr), .i_ready(ready), .o_valid(v0), .o_word(wd0), .o_state(st0),
    .o_pulse(p0), .o_overrun(ov0), .o_alarm(al0)
  );
  // lowest tap at bit 9 so the 8 seed LSBs reach s[0] untouched by feedback
  trng_ring_collector #(.TAPS(32'h0410_8200), .DECIM(1), .OUT_W(8), .RCT_LIMIT(16)) u1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_w(w), .i_load(load), .i_seed(seed),
    .i_clr(clr), .i_ready(ready), .o_valid(v1), .o_word(wd1), .o_state(st1),
    .o_pulse(p1), .o_overrun(ov1), .o_alarm(al1)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic load_seed(input logic [31:0] s);
    en = 1'b0; seed = s; load = 1'b1;
    step;
    load = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1; en = 1'b0; w = '0; load = 1'b0; seed = '0; clr = 1'b0; ready = 1'b0;
    tv[0] = '{32'h0000_0001, 5'b00000, 32'h8410_8210, 1'b0};
    tv[1] = '{32'h0000_0000, 5'b10101, 32'h0000_4104, 1'b0};
    tv[2] = '{32'h0000_0002, 5'b00000, 32'h0000_0001, 1'b1};
    tv[3] = '{32'h8000_0000, 5'b00000, 32'h4000_0000, 1'b0};
    tv[4] = '{32'h0000_0000, 5'b11111, 32'h0000_4924, 1'b0};
    tv[5] = '{32'h0000_0003, 5'b00001, 32'h8410_8215, 1'b1};
    tv[6] = '{32'hFFFF_FFFF, 5'b00000, 32'hFBEF_7DEF, 1'b1};
    #3;
    chk("rst_state", st0, 0); chk("rst_valid", v0, 0); chk("rst_word", wd0, 0);
    chk("rst_pulse", p0, 0); chk("rst_ovr", ov0, 0); chk("rst_alarm", al0, 0);
    #4 rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      load_seed(tv[i].seed);
      en = 1'b1; w = tv[i].w;
      step;
      en = 1'b0; w = '0;
      chk($sformatf("vec%0d_state", i), st0, tv[i].st);
      chk($sformatf("vec%0d_pulse", i), p0, tv[i].p);
    end
    load_seed(32'h1);
    step; step;
    chk("hold_state", st0, 32'h1);
    ready = 1'b1;
    load_seed(32'hA5);
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step;
      if (i == 7) chk("pack_valid_early", v1, 0);
    end
    chk("pack_valid", v1, 1); chk("pack_word", wd1, 8'hA5);
    step;
    chk("pack_valid_drop", v1, 0);
    ready = 1'b0;
    load_seed(32'hA5);
    en = 1'b1;
    repeat (8) step;
    chk("ovr_first_valid", v1, 1); chk("ovr_first_word", wd1, 8'hA5); chk("ovr_none", ov1, 0);
    repeat (7) step;
    chk("ovr_before", ov1, 0);
    step;
    chk("ovr_set", ov1, 1); chk("ovr_word_held", wd1, 8'hA5); chk("ovr_valid_held", v1, 1);
    en = 1'b0; clr = 1'b1;
    step;
    clr = 1'b0;
    chk("ovr_clr", ov1, 0); chk("ovr_clr_valid", v1, 1);
    ready = 1'b1;
    step;
    chk("hs_valid_fall", v1, 0);
    load_seed(32'h0);
    en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step;
      if (i == 8) begin chk("hlth_word_valid", v1, 1); chk("hlth_word", wd1, 0); end
      if (i == 15) chk("hlth_alarm_early", al1, 0);
    end
    chk("hlth_alarm", al1, 1); chk("hlth_suppress", v1, 0);
    vcnt = 0;
    repeat (24) begin step; vcnt += int'(v1); end
    chk("hlth_no_valid", vcnt, 0); chk("hlth_alarm_sticky", al1, 1);
    clr = 1'b1;
    load_seed(32'hA5);
    clr = 1'b0;
    chk("hlth_clr", al1, 0);
    en = 1'b1;
    repeat (8) step;
    chk("hlth_resume_valid", v1, 1); chk("hlth_resume_word", wd1, 8'hA5);
    ready = 1'b0;
    load_seed(32'hA5);
    en = 1'b1;
    repeat (11) step;
    chk("arst_pre_valid", v1, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", st1, 0); chk("arst_valid", v1, 0); chk("arst_word", wd1, 0);
    chk("arst_pulse", p1, 0); chk("arst_ovr", ov1, 0); chk("arst_alarm", al1, 0);
    #2 rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step;
      if (i == 7) chk("arst_v1_early", v1, 0);
      if (i == 8) begin chk("arst_v1", v1, 1); chk("arst_wd1", wd1, 0); end
      if (i == 31) chk("arst_v0_early", v0, 0);
      if (i == 32) chk("arst_v0", v0, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trng_ring_collector.md
# trng_ring_collector

Parametrised successor of the fixed 32-bit ring generator in the TRNG entropy path. A Galois-form ring generator of configurable width, taps and injection points absorbs raw entropy bits. Its LSB is decimated and packed into OUT_W-bit words, which are delivered over a valid/ready interface. The block also provides synchronous seed loading, overrun detection and a sticky repetition-count health alarm.

## Interface
- WIDTH, 32: ring generator length, ≥ 8
- TAPS, 32'h0410_8210: feedback mask; bit k set means s[0] is XORed into next[k]; default realises x32+x27+x21+x16+x10+x5+1
- NO_INJ, 5: number of entropy injection inputs
- INJ_BASE, 2: state bit receiving i_w[0]
- INJ_STRIDE, 3: spacing of injection bits; INJ_BASE+(NO_INJ-1)*INJ_STRIDE < WIDTH-1
- DECIM, 4: enabled cycles per sampled bit, ≥ 1
- OUT_W, 8: bits per output word, ≥ 2
- RCT_LIMIT, 32: consecutive identical samples that raise the alarm, ≥ 2
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  1  advance ring, decimator and collector
- i_w  in  NO_INJ  raw entropy bits
- i_load  in  1  synchronous seed load
- i_seed  in  WIDTH  seed value
- i_clr  in  1  clear o_overrun and o_alarm
- i_ready  in  1  consumer ready
- o_valid  out  1  o_word holds a word
- o_word  out  OUT_W  packed random word, first sampled bit in the LSB
- o_state  out  WIDTH  ring generator state
- o_pulse  out  1  state bit 0
- o_overrun  out  1  sticky: a word was dropped
- o_alarm  out  1  sticky: repetition-count failure

## Operation
- Ring update when i_en=1 and i_load=0:
  - next[WIDTH-1] = s[0]
  - next[k] = s[k+1] ^ (TAPS[k] & s[0]) ^ inj[k], for k < WIDTH-1
  - inj[INJ_BASE+j*INJ_STRIDE] = i_w[j]; all other inj bits are 0
- When i_en=0, the ring, decimator, collector and health counter all hold.
- i_load has priority over i_en:
  - state <= i_seed
  - decimation counter, collector bit count and run counter cleared
  - o_word, o_valid and the sticky flags are unaffected
- Decimator: counter dcnt runs 0..DECIM-1 over enabled cycles. On an enabled cycle with dcnt=DECIM-1, the current s[0] is sampled.
- Collector: each sample is shifted in at the MSB side, so the first sample ends in o_word[0]. When the OUT_W-th sample arrives, a word completes and the bit count wraps to 0.
- Health test:
  - The run counter counts consecutive equal samples, starting at 1 on any change.
  - When it reaches RCT_LIMIT, o_alarm <= 1. The counter saturates.
- Word delivery on completion:
  - If o_alarm or the alarm is rising this cycle: the word is discarded silently.
  - Else if o_valid=1 and i_ready=0: the word is discarded and o_overrun <= 1.
  - Else: o_word <= new word, o_valid <= 1.
- Handshake: a transfer occurs on o_valid & i_ready. If no word completes in the same cycle, o_valid falls next cycle. If one does, o_word is replaced and o_valid stays 1.
- i_clr clears both sticky flags next cycle. If a flag sets in the same cycle, the set wins.
- An all-zero state with i_w=0 is a legal fixed point; the health test is the detection path.

## Timing
- Reset values: state 0, o_pulse 0, o_valid 0, o_word 0, o_overrun 0, o_alarm 0, all counters 0.
- Every output is registered; o_state and o_pulse reflect the state after the last edge.
- Sample-to-word latency: o_valid rises on the edge that captures the OUT_W-th sample.
- First word after load or reset with i_en held at 1: o_valid is high after DECIM*OUT_W edges.
- Reset mid-word: the partial word is lost. A held word is dropped and o_valid is deasserted immediately (asynchronous).
- Throughput: one word per DECIM*OUT_W enabled cycles. The consumer must accept within that window to avoid overrun.

## Structure
- The shared package trng_pkg holds:
  - default TAPS for widths 16, 32 and 64
  - a parameter-legality check function covering the INJ, DECIM, OUT_W and RCT constraints
- Sub-module trng_ring_core: state register and next-state logic only, with parameters WIDTH, TAPS, NO_INJ, INJ_BASE and INJ_STRIDE. It generalises the previous ring generator.
- Decimator, collector, health test and handshake logic stay in the top module.

## Test plan
- Deterministic step: load 32'h0000_0001, i_w=0, one enabled cycle -> o_state=32'h8410_8210, o_pulse=0.
- Injection: load 0, i_w=5'b10101, one enabled cycle -> o_state=32'h0000_4104 (bits 2, 8, 14).
- Packing: DECIM=1, OUT_W=8, load 32'h0000_00A5, i_w=0, i_ready=1 -> first o_word=8'hA5, o_valid high after exactly 8 edges.
- Overrun: i_ready=0 throughout -> first word held, o_overrun=1 after the second completion, o_word unchanged; i_clr -> o_overrun=0.
- Health: DECIM=1, OUT_W=8, RCT_LIMIT=16, state 0, i_w=0 -> one word 8'h00 delivered; o_alarm=1 on the 16th sample with the second word suppressed; no further o_valid until i_clr.
- Async reset: assert i_rst while o_valid=1 and the collector is mid-word -> all outputs 0 immediately; first word after release arrives after DECIM*OUT_W enabled edges.
